// File: rtl/endgame_text_renderer.sv
// Game-over text overlay: "You Win"/"You Lost" and "Pts: dddd" from an 8x16 glyph ROM.
// Define ENDGAME_TEXT_2X_EN to draw every glyph pixel as a 2x2 block.
module endgame_text_renderer #(
  parameter int LINE1_X = 288,
  parameter int LINE1_Y = 208,
  parameter int LINE2_X = 284,
  parameter int LINE2_Y = 240
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [13:0] score,
  input  logic        win,
  input  logic        score_load,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pixel_valid,
  output logic [9:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on,
  output logic        busy
);

`ifdef ENDGAME_TEXT_2X_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  localparam int CW  = 8 << SH;
  localparam int CH  = 16 << SH;
  localparam int L1W = 8 * CW;
  localparam int L2W = 9 * CW;

  localparam logic [9:0] L1X = 10'(LINE1_X);
  localparam logic [9:0] L1Y = 10'(LINE1_Y);
  localparam logic [9:0] L2X = 10'(LINE2_X);
  localparam logic [9:0] L2Y = 10'(LINE2_Y);
  localparam logic [9:0] L1WV = 10'(L1W);
  localparam logic [9:0] L2WV = 10'(L2W);
  localparam logic [9:0] CHV = 10'(CH);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t      state;
  logic        win_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [15:0] digits;

  logic [13:0] sat;
  logic [15:0] adj;
  logic [15:0] bcd_nx;

  assign sat = (score > 14'd9999) ? 14'd9999 : score;

  // Double dabble: add 3 to any nibble >= 5, then shift in the next bit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_nx = {adj[14:0], bin_q[13]};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      win_q  <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      digits <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (score_load) begin
            win_q <= win;
            bin_q <= sat;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= bcd_nx;
          bin_q <= {bin_q[12:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            digits <= bcd_nx;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [4:0] l1_glyph(
    input logic [2:0] c,
    input logic       w
  );
    logic [4:0] g;
    case (c)
      3'd0:    g = 5'd1;
      3'd1:    g = 5'd2;
      3'd2:    g = 5'd3;
      3'd3:    g = 5'd0;
      3'd4:    g = w ? 5'd15 : 5'd4;
      3'd5:    g = w ? 5'd14 : 5'd2;
      3'd6:    g = w ? 5'd16 : 5'd5;
      default: g = w ? 5'd0  : 5'd11;
    endcase
    return g;
  endfunction

  function automatic logic [4:0] dig_glyph(input logic [3:0] d);
    return 5'd18 + {1'b0, d};
  endfunction

  function automatic logic [4:0] l2_glyph(
    input logic [3:0]  c,
    input logic [15:0] d
  );
    logic [4:0] g;
    case (c)
      4'd0:    g = 5'd9;
      4'd1:    g = 5'd11;
      4'd2:    g = 5'd5;
      4'd3:    g = 5'd17;
      4'd4:    g = 5'd0;
      4'd5:    g = dig_glyph(d[15:12]);
      4'd6:    g = dig_glyph(d[11:8]);
      4'd7:    g = dig_glyph(d[7:4]);
      default: g = dig_glyph(d[3:0]);
    endcase
    return g;
  endfunction

  logic [9:0] dx1, dy1, dx2, dy2;
  logic       hit1, hit2;
  logic [2:0] cell1;
  logic [3:0] cell2;
  logic [3:0] row1, row2;
  logic [2:0] xo1, xo2;

  assign dx1 = DrawX - L1X;
  assign dy1 = DrawY - L1Y;
  assign dx2 = DrawX - L2X;
  assign dy2 = DrawY - L2Y;

  // The >= tests reject pixels left of or above a box before subtraction wraps.
  assign hit1 = pixel_valid
    && (DrawX >= L1X) && (dx1 < L1WV)
    && (DrawY >= L1Y) && (dy1 < CHV);
  assign hit2 = pixel_valid
    && (DrawX >= L2X) && (dx2 < L2WV)
    && (DrawY >= L2Y) && (dy2 < CHV);

  assign cell1 = 3'(dx1 >> (3 + SH));
  assign cell2 = 4'(dx2 >> (3 + SH));
  assign row1  = 4'(dy1 >> SH);
  assign row2  = 4'(dy2 >> SH);
  assign xo1   = 3'(dx1 >> SH);
  assign xo2   = 3'(dx2 >> SH);

  logic [9:0] addr_nx;
  logic       in_nx;
  logic [2:0] xoff_nx;

  always_comb begin
    addr_nx = '0;
    in_nx   = 1'b0;
    xoff_nx = '0;
    if (hit1) begin
      addr_nx = {1'b0, l1_glyph(cell1, win_q), row1};
      in_nx   = 1'b1;
      xoff_nx = xo1;
    end else if (hit2) begin
      addr_nx = {1'b0, l2_glyph(cell2, digits), row2};
      in_nx   = 1'b1;
      xoff_nx = xo2;
    end
  end

  logic       in_q;
  logic [2:0] xoff_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      in_q     <= 1'b0;
      xoff_q   <= '0;
      text_on  <= 1'b0;
    end else begin
      rom_addr <= addr_nx;
      in_q     <= in_nx;
      xoff_q   <= xoff_nx;
      text_on  <= in_q & rom_data[3'd7 - xoff_q];
    end
  end

endmodule

// File: doc/endgame_text_renderer.md
Name: endgame_text_renderer

Overview:
- Reads the 8x16 endgame glyph ROM and renders two fixed text lines into the VGA pixel stream on the game-over screen.
- Line 1 is "You Win" or "You Lost". Line 2 is "Pts: dddd", the final score in decimal.
- Converts the binary score to BCD with an iterative double-dabble engine.
- Drives the ROM address from DrawX/DrawY through a 2-stage pipeline and outputs a per-pixel text_on flag to the colour mapper.

Parameters:
- LINE1_X, 288, left pixel of line 1 (8 cells).
- LINE1_Y, 208, top pixel row of line 1.
- LINE2_X, 284, left pixel of line 2 (9 cells).
- LINE2_Y, 240, top pixel row of line 2.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  synchronous active-low reset
- score  in  14  final score, binary
- win  in  1  1 = player won
- score_load  in  1  single-cycle pulse; capture score and win
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- pixel_valid  in  1  DrawX/DrawY lie in the visible area
- rom_addr  out  10  glyph ROM address = glyph*16 + row
- rom_data  in  8  ROM byte, combinational from rom_addr; MSB = leftmost pixel
- text_on  out  1  current pixel (2 cycles delayed) is a lit text pixel
- busy  out  1  BCD conversion in progress

Behaviour:
- Interface is fixed: one clock, Clk; reset is synchronous and active-low, Reset_n.
- Reset (Reset_n=0 at a Clk edge): text_on=0, busy=0, rom_addr=0, win_q=0, digits=0000, conversion state cleared. Reset mid-conversion aborts it; digits read 0000.
- Glyph codes:
  - 0 blank, 1 Y, 2 o, 3 u, 4 L, 5 s, 6 e, 7 r, 8 c, 9 P, 10 a, 11 t, 12 p, 13 q, 14 i, 15 W, 16 n, 17 ':'.
  - Digit d is glyph 18+d.
- Line 1 cells:
  - win_q=1: Y o u blank W i n blank (1,2,3,0,15,14,16,0).
  - win_q=0: Y o u blank L o s t (1,2,3,0,4,2,5,11).
- Line 2 cells: P t s : blank D3 D2 D1 D0, where D3 is the thousands digit. Leading zeros are displayed.
- Score load:
  - score_load while busy=0: latch win into win_q immediately.
  - Latch min(score, 9999); any value >9999 saturates to 9999.
  - busy rises the next cycle and stays high exactly 14 cycles (one shift/add-3 per cycle).
  - The displayed digit registers update on the cycle busy falls. The old digits are shown until then.
  - score_load while busy=1 is ignored, including win.
- Pipeline:
  - Stage 1 (edge after DrawX/DrawY are presented):
    - Register rom_addr = glyph*16 + (DrawY - LINE_Y).
    - Register x offset = (DrawX - LINE_X) mod 8 and an in-area flag.
    - In-area means pixel_valid=1 and inside a line's cell box (width cells*8, height 16).
    - Outside every box: rom_addr=0 and the in-area flag is 0.
  - Stage 2 (next edge): text_on = in_area_q & rom_data[7 - xoff_q].
  - Total latency is 2 cycles; a new pixel is accepted every cycle with no stalls.
- Line boxes never overlap with the default parameters. If they do, line 1 has priority.
- Cell and row arithmetic is unsigned 10-bit. A pixel left of or above a box start is out of area; no wrap-around.

Optional Feature:
- Macro: ENDGAME_TEXT_2X_EN.
- Defined: each glyph pixel is drawn 2x2.
  - Cells are 16x32; line boxes double in width and height.
  - row = (DrawY - LINE_Y) >> 1; xoff = ((DrawX - LINE_X) >> 1) mod 8.
  - Latency is unchanged.
- Undefined: 1x rendering as specified above.

Test Plan:
1. Reset: Reset_n=0 for 2 cycles, then release -> text_on=0, busy=0, rom_addr=0, digits 0000. Pixel (LINE2_X+40+3=327, 242) -> rom_addr=18*16+2=290.
2. win=0, DrawX=288, DrawY=210, pixel_valid=1 -> rom_addr=18 ('Y' row 2) after 1 cycle; text_on=1 after 2 cycles. DrawX=290 ('Y' row 2 bit 5 = 0) -> text_on=0.
3. score_load with score=1234 -> busy high for exactly 14 cycles, then digits 1,2,3,4. Pixel (327, 242) -> rom_addr=19*16+2=306, text_on=1; pixel (324, 242) -> text_on=0.
4. score_load with score=12000 -> digits 9,9,9,9. A second score_load with score=5 while busy -> ignored; digits stay 9999.
5. win=1 loaded: pixel (LINE1_X+32=320, 210) -> rom_addr=15*16+2=242 ('W'). pixel_valid=0 at the same coordinates -> text_on=0, rom_addr=0.
6. Reset_n pulsed low at busy cycle 7 of a load of 4321 -> busy=0 next cycle, digits 0000, no late update.
